// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types for the data memory arbiter
package dmem_arb_pkg;

    // Widths of the request/response records; the arbiter's defaults follow these.
    localparam int DMEM_DATA_W = 32;
    localparam int DMEM_ADDR_W = 10;

    // Which requester the response in flight belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_C    = 2'd1,
        OWN_H    = 2'd2
    } owner_e;

    typedef struct packed {
        logic                   valid;
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DMEM_DATA_W-1:0] wdata;
    } dmem_req_t;

    typedef struct packed {
        logic                   valid;
        logic [DMEM_DATA_W-1:0] rdata;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_arb_prio.sv
// rtl/dmem_arb_prio.sv - core-priority grant with host starvation counter
module dmem_arb_prio #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic c_valid,
    input  logic h_valid,
    output logic grant_c,
    output logic grant_h
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    // Core wins conflicts until the host has lost WAIT_LIMIT in a row; nothing is granted in reset.
    always_comb begin
        grant_h = !rst && h_valid && (!c_valid || (wait_cnt == WAIT_LIMIT));
        grant_c = !rst && c_valid && !grant_h;
    end

    // Count consecutive host losses; a host grant clears it, host idle leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (grant_h) begin
            wait_cnt <= 4'd0;
        end else if (c_valid && h_valid && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the dmem port between core and host requesters
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DMEM_DATA_W,
    parameter int ADDR_WIDTH = DMEM_ADDR_W,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c_valid,
    output logic                  c_ready,
    input  logic                  c_we,
    input  logic [ADDR_WIDTH-1:0] c_addr,
    input  logic [DATA_WIDTH-1:0] c_wdata,
    output logic                  c_rsp_valid,
    output logic [DATA_WIDTH-1:0] c_rsp_rdata,
    input  logic                  h_valid,
    output logic                  h_ready,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [DATA_WIDTH-1:0] h_wdata,
    output logic                  h_rsp_valid,
    output logic [DATA_WIDTH-1:0] h_rsp_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           conflict_cnt
);

    logic      grant_c;
    logic      grant_h;
    dmem_req_t c_req;
    dmem_req_t h_req;
    dmem_req_t sel_req;
    dmem_rsp_t c_rsp;
    dmem_rsp_t h_rsp;
    owner_e    owner;
    logic      owner_we;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic [DATA_WIDTH-1:0] c_hold;
    logic [DATA_WIDTH-1:0] h_hold;

    dmem_arb_prio #(
        .MAX_WAIT (MAX_WAIT)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .c_valid (c_valid),
        .h_valid (h_valid),
        .grant_c (grant_c),
        .grant_h (grant_h)
    );

    // Request mux: the core's request drives the memory bus whenever the host is not granted.
    always_comb begin
        c_req   = '{valid: c_valid, we: c_we, addr: c_addr, wdata: c_wdata};
        h_req   = '{valid: h_valid, we: h_we, addr: h_addr, wdata: h_wdata};
        sel_req = grant_h ? h_req : c_req;
    end

    assign c_ready   = grant_c;
    assign h_ready   = grant_h;
    assign mem_we    = sel_req.we && (grant_c || grant_h);
    assign mem_addr  = sel_req.addr;
    assign mem_wdata = sel_req.wdata;

    // Remember who issued last cycle's access and whether it was a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
        end else begin
            owner    <= grant_h ? OWN_H : (grant_c ? OWN_C : OWN_NONE);
            owner_we <= mem_we;
        end
    end

    // Writes are acknowledged with zero data; reads forward the registered dmem output.
    assign rsp_data = owner_we ? '0 : mem_rdata;

    // Response fan-out: only the owner sees valid, the other port keeps its last data.
    always_comb begin
        c_rsp.valid = !rst && (owner == OWN_C);
        h_rsp.valid = !rst && (owner == OWN_H);
        c_rsp.rdata = rst ? '0 : (c_rsp.valid ? rsp_data : c_hold);
        h_rsp.rdata = rst ? '0 : (h_rsp.valid ? rsp_data : h_hold);
    end

    assign c_rsp_valid = c_rsp.valid;
    assign c_rsp_rdata = c_rsp.rdata;
    assign h_rsp_valid = h_rsp.valid;
    assign h_rsp_rdata = h_rsp.rdata;

    // Hold registers carry each port's last response data between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_hold <= '0;
            h_hold <= '0;
        end else begin
            c_hold <= c_rsp.rdata;
            h_hold <= h_rsp.rdata;
        end
    end

    // Saturating count of cycles where both requesters wanted the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= 16'd0;
        end else if (c_valid && h_valid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule
